alm_mac_seq_ctrl: RTL



---
 rtl/alm_mac_seq_pkg.sv | 5 +
 rtl/alm_mac_seq_cnt.sv | 21 ++
 rtl/alm_mac_seq_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/alm_mac_seq_pkg.sv
// alm_mac_seq_pkg: shared state encoding and accumulator width for the MAC sequencer
package alm_mac_seq_pkg;
  localparam int ALM_MAC_ACC_W = 27;
  typedef enum logic [2:0] {IDLE, CLEAR, ACC, DRAIN, OUT} state_t;
endpackage

// File: rtl/alm_mac_seq_cnt.sv
// alm_mac_seq_cnt: loadable down-counter with zero and last (count==1) flags
module alm_mac_seq_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  assign last = cnt == W'(1);
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/alm_mac_seq_ctrl.sv
// alm_mac_seq_ctrl: dot-product sequencer driving the ALM MAC; optional stall counter via ALM_MAC_SEQ_STALL_CNT_EN
module alm_mac_seq_ctrl
  import alm_mac_seq_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int ACC_W   = ALM_MAC_ACC_W,
  parameter int MAC_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic        [LEN_W-1:0] vec_len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       in_a,
  input  logic signed [7:0]       in_b,
  output logic signed [7:0]       mac_a,
  output logic signed [7:0]       mac_b,
  output logic                    mac_acc_en,
  output logic                    mac_reset,
  input  logic signed [ACC_W-1:0] mac_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_result
`ifdef ALM_MAC_SEQ_STALL_CNT_EN
  , output logic      [LEN_W+3:0] stall_cnt
`endif
);
  state_t state;
  logic beat, l_zero, l_last, d_zero, d_last, d_load, d_done;
  assign in_ready   = state == ACC;
  assign beat       = in_ready && in_valid;
  assign mac_acc_en = beat;
  assign mac_a      = beat ? in_a : '0;
  assign mac_b      = beat ? in_b : '0;
  assign mac_reset  = reset || state == CLEAR;
  assign busy       = state != IDLE;
  assign out_valid  = state == OUT;
  // drain timer waits MAC_LAT cycles past the last accumulate, then samples the MAC
  assign d_load = (state == CLEAR && l_zero) || (beat && l_last);
  assign d_done = d_last || d_zero;
  alm_mac_seq_cnt #(.W(LEN_W)) u_len (
    .clk(clk), .rst(reset), .load(state == IDLE && start), .load_val(vec_len),
    .dec(beat), .zero(l_zero), .last(l_last)
  );
  alm_mac_seq_cnt #(.W(LEN_W)) u_drain (
    .clk(clk), .rst(reset), .load(d_load), .load_val(LEN_W'(MAC_LAT + 1)),
    .dec(state == DRAIN), .zero(d_zero), .last(d_last)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_result <= '0;
    end else begin
      unique case (state)
        IDLE:  if (start) state <= CLEAR;
        CLEAR: state <= l_zero ? DRAIN : ACC;
        ACC:   if (beat && l_last) state <= DRAIN;
        DRAIN: if (d_done) begin
          state      <= OUT;
          out_result <= mac_result;
        end
        OUT:   if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALM_MAC_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || state == CLEAR) stall_cnt <= '0;
    else if (state == ACC && !in_valid && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule
